collision_scan_ctrl: RTL



---
 rtl/snake_pkg.sv | 56 +++++
 rtl/segment_select.sv | 20 ++
 rtl/collision_scan_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the two-snake game: coordinate and length types,
// scan-state encoding and phase sequencing helpers.
// Optional feature macro: COLLISION_SELF_CHECK_EN adds the self-overlap
// phases SCAN_C and SCAN_D.
package snake_pkg;

    localparam int MAX_LEN = 15;
    localparam int NUM_LEN = 10;
    localparam int LEN_W   = 4;
    localparam int BODY_W  = MAX_LEN * NUM_LEN;

    typedef logic [NUM_LEN-1:0] seg_t;
    typedef logic [LEN_W-1:0]   len_t;

`ifdef COLLISION_SELF_CHECK_EN
    typedef enum logic [2:0] {IDLE, SCAN_A, SCAN_B, SCAN_C, SCAN_D, DONE} scan_state_t;
`else
    typedef enum logic [2:0] {IDLE, SCAN_A, SCAN_B, DONE} scan_state_t;
`endif

    function automatic len_t clamp_len(input len_t len);
        return (len > len_t'(MAX_LEN)) ? len_t'(MAX_LEN) : len;
    endfunction

    // First non-empty phase after cur; later checks override earlier ones so
    // the earliest eligible phase wins.
    function automatic scan_state_t next_phase(input scan_state_t cur,
                                               input len_t l1,
                                               input len_t l2);
        scan_state_t nxt;
        nxt = DONE;
`ifdef COLLISION_SELF_CHECK_EN
        if (cur != SCAN_D && cur != DONE && l2 > len_t'(1))
            nxt = SCAN_D;
        if ((cur == IDLE || cur == SCAN_A || cur == SCAN_B) && l1 > len_t'(1))
            nxt = SCAN_C;
`endif
        if ((cur == IDLE || cur == SCAN_A) && l2 != '0)
            nxt = SCAN_B;
        if (cur == IDLE && l1 != '0)
            nxt = SCAN_A;
        return nxt;
    endfunction

    // Self-overlap phases skip the head itself and start at segment 1.
    function automatic len_t first_idx(input scan_state_t s);
        len_t r;
        r = '0;
`ifdef COLLISION_SELF_CHECK_EN
        if (s == SCAN_C || s == SCAN_D)
            r = len_t'(1);
`endif
        return r;
    endfunction

endpackage

// File: rtl/segment_select.sv
// Combinational segment picker: returns segment idx of a flattened body.
// An index beyond the last stored segment reads as zero.
module segment_select
    import snake_pkg::*;
(
    input  logic [BODY_W-1:0] body,
    input  len_t              idx,
    output seg_t              seg
);

    // One-hot style mux over the stored segments.
    always_comb begin
        seg = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx == len_t'(i))
                seg = body[i*NUM_LEN +: NUM_LEN];
        end
    end

endmodule

// File: rtl/collision_scan_ctrl.sv
// Time-multiplexed collision scanner for the two-snake game. One shared
// comparator walks the snapshotted bodies one segment per clock and reports
// sticky per-snake death flags with a done pulse.
// Optional feature macro: COLLISION_SELF_CHECK_EN (self-overlap phases).
//
// state  | meaning
// IDLE   | waiting for start
// SCAN_A | head2 against body1
// SCAN_B | head1 against body2
// SCAN_C | head1 against body1[1..]  (self-check build only)
// SCAN_D | head2 against body2[1..]  (self-check build only)
// DONE   | done pulse, dead flags hold the new result
module collision_scan_ctrl
    import snake_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic [BODY_W-1:0] snake1,
    input  logic [BODY_W-1:0] snake2,
    input  logic [LEN_W-1:0]  len1,
    input  logic [LEN_W-1:0]  len2,
    output logic              busy,
    output logic              done,
    output logic              dead1,
    output logic              dead2
);

    scan_state_t       state;
    logic [BODY_W-1:0] snap1;
    logic [BODY_W-1:0] snap2;
    len_t              snap_len1;
    len_t              snap_len2;
    len_t              idx;
    logic              hit1;
    logic              hit2;

    len_t              in_len1;
    len_t              in_len2;
    logic              scanning;
    logic              body_is1;
    logic              head_is1;
    logic [BODY_W-1:0] body_src;
    logic [BODY_W-1:0] head_src;
    seg_t              body_seg;
    seg_t              head_seg;
    logic              seg_match;
    logic              last_seg;
    len_t              phase_len;
    logic              hit1_n;
    logic              hit2_n;
    scan_state_t       nxt_idle;
    scan_state_t       nxt_scan;

    assign in_len1 = clamp_len(len1);
    assign in_len2 = clamp_len(len2);

    // Route the snapshots to the comparator for the current phase.
    always_comb begin
        scanning = (state == SCAN_A) || (state == SCAN_B);
        body_is1 = (state == SCAN_A);
        head_is1 = (state == SCAN_B);
`ifdef COLLISION_SELF_CHECK_EN
        scanning = scanning || (state == SCAN_C) || (state == SCAN_D);
        body_is1 = body_is1 || (state == SCAN_C);
        head_is1 = head_is1 || (state == SCAN_C);
`endif
        body_src  = body_is1 ? snap1 : snap2;
        head_src  = head_is1 ? snap1 : snap2;
        phase_len = body_is1 ? snap_len1 : snap_len2;
        seg_match = (head_seg == body_seg);
        last_seg  = seg_match || (idx == phase_len - len_t'(1));
        // The head snake of the phase is the one that dies on a match.
        hit1_n    = hit1 | (scanning & seg_match & head_is1);
        hit2_n    = hit2 | (scanning & seg_match & ~head_is1);
        nxt_idle  = next_phase(IDLE, in_len1, in_len2);
        nxt_scan  = next_phase(state, snap_len1, snap_len2);
    end

    segment_select u_body_sel (
        .body (body_src),
        .idx  (idx),
        .seg  (body_seg)
    );

    segment_select u_head_sel (
        .body (head_src),
        .idx  (len_t'(0)),
        .seg  (head_seg)
    );

    // Scan sequencer with registered busy/done/dead outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            snap1     <= '0;
            snap2     <= '0;
            snap_len1 <= '0;
            snap_len2 <= '0;
            idx       <= '0;
            hit1      <= 1'b0;
            hit2      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dead1     <= 1'b0;
            dead2     <= 1'b0;
        end else begin
            // A DONE-entry update below overrides a coincident clear.
            if (clear) begin
                dead1 <= 1'b0;
                dead2 <= 1'b0;
            end
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        snap1     <= snake1;
                        snap2     <= snake2;
                        snap_len1 <= in_len1;
                        snap_len2 <= in_len2;
                        hit1      <= 1'b0;
                        hit2      <= 1'b0;
                        idx       <= first_idx(nxt_idle);
                        state     <= nxt_idle;
                        busy      <= 1'b1;
                        if (nxt_idle == DONE) begin
                            done  <= 1'b1;
                            dead1 <= dead1;
                            dead2 <= dead2;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    hit1 <= hit1_n;
                    hit2 <= hit2_n;
                    if (last_seg) begin
                        state <= nxt_scan;
                        idx   <= first_idx(nxt_scan);
                        if (nxt_scan == DONE) begin
                            done  <= 1'b1;
                            dead1 <= dead1 | hit1_n;
                            dead2 <= dead2 | hit2_n;
                        end
                    end else begin
                        idx <= idx + len_t'(1);
                    end
                end
            endcase
        end
    end

endmodule
